mem1_bank_scheduler: RTL
========================

# mem1_bank_scheduler

Ping-pong bank scheduler for the MEM1 frame buffer. The SPI write controller fills one 20-line x 20-bit image bank while the downstream STFT/CNN reader consumes the other. The scheduler decides which bank is written and which is read, and gates the writer when no bank is free. It sequences the read handshake, clears the writer's counters between images, and flags overruns.

## Interface
Parameters:
- FRAME_CNT_WL, 16: width of the consumed-frame counter.

Ports:
- iCLK  in  1  system clock; all logic on rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iWR_DONE  in  1  one-cycle pulse from the MEM1 write controller: the 20th line of the current image is written.
- iRD_READY  in  1  level; the reader can accept a new frame.
- iRD_DONE  in  1  one-cycle pulse from the reader: the bank in oRD_BANK is fully consumed.
- oWR_BANK  out  1  bank selected for writing; drives the MEM1 write-address MSB.
- oWR_ALLOW  out  1  enable gate ANDed into the write controller iEN.
- oWR_CLR  out  1  one-cycle pulse into the write controller iCLR.
- oRD_START  out  1  one-cycle pulse: the reader starts on oRD_BANK.
- oRD_BANK  out  1  bank being read; stable from oRD_START until iRD_DONE.
- oRD_BUSY  out  1  read in progress.
- oOVF  out  1  sticky overrun flag.
- oFRAME_CNT  out  FRAME_CNT_WL  count of frames consumed; wraps modulo 2^FRAME_CNT_WL.

## Operation
- Each bank has a 2-bit state: FREE, FULL or READ.
- Writer FSM has two states:
  - W_ACTIVE: oWR_ALLOW=1.
  - W_WAIT: oWR_ALLOW=0.
- Reader FSM has two states:
  - R_IDLE: oRD_BUSY=0.
  - R_BUSY: oRD_BUSY=1.
- Banks are written and read in strict alternation: 0,1,0,1,… Read pointer rd_ptr names the oldest FULL bank.
- W_ACTIVE with iWR_DONE:
  - bank[oWR_BANK] becomes FULL; oWR_CLR=1 for the next cycle.
  - If bank[~oWR_BANK] is FREE (including freed by iRD_DONE in the same cycle), oWR_BANK toggles and the FSM stays in W_ACTIVE.
  - Otherwise the FSM goes to W_WAIT and oWR_BANK is held.
- W_WAIT: when bank[~oWR_BANK] is FREE, oWR_BANK toggles and the FSM returns to W_ACTIVE; oWR_ALLOW=1 from the next cycle.
- iWR_DONE while in W_WAIT: oOVF sets and stays set until iRST. No state change.
- R_IDLE with iRD_READY=1 and bank[rd_ptr]==FULL:
  - oRD_START=1 for one cycle; oRD_BANK=rd_ptr; bank[rd_ptr] becomes READ; FSM goes to R_BUSY.
- R_BUSY with iRD_DONE:
  - bank[oRD_BANK] becomes FREE; rd_ptr toggles; oFRAME_CNT increments; FSM returns to R_IDLE.
- iRD_DONE in R_IDLE is ignored.
- iWR_DONE and iRD_DONE in the same cycle: both updates apply in that cycle.
- iRST at any point, including mid-frame:
  - both banks FREE; W_ACTIVE, oWR_BANK=0, rd_ptr=0, R_IDLE.
  - all outputs 0 except oWR_ALLOW=1.
  - a pending read is abandoned.

## Timing
- All outputs are registered. Reset values: oWR_BANK=0, oWR_ALLOW=1, oWR_CLR=0, oRD_START=0, oRD_BANK=0, oRD_BUSY=0, oOVF=0, oFRAME_CNT=0.
- iWR_DONE at edge N:
  - oWR_CLR high in cycle N+1.
  - new oWR_BANK or oWR_ALLOW=0 visible in cycle N+1.
  - earliest oRD_START in cycle N+2 (needs iRD_READY=1 at edge N+1).
- oRD_START and oRD_BUSY rise in the same cycle. oRD_BUSY falls the cycle after the iRD_DONE edge; oFRAME_CNT updates in that same cycle.
- W_WAIT release: iRD_DONE at edge N gives oWR_ALLOW=1 and the toggled oWR_BANK in cycle N+1.
- Back-to-back read: iRD_DONE at edge N with the other bank FULL and iRD_READY=1 gives oRD_START in cycle N+2.
- oFRAME_CNT at all-ones wraps to 0.

## Test plan
- Reset, then iWR_DONE → bank0 FULL, oWR_BANK=1, oWR_CLR pulse 1 cycle; with iRD_READY=1, oRD_START pulse 2 cycles after iWR_DONE, oRD_BANK=0, oRD_BUSY=1.
- Two iWR_DONE pulses with iRD_READY=0 → oWR_ALLOW=0, oWR_BANK=1. A third iWR_DONE → oOVF=1 and sticks. Raising iRD_READY → oRD_START with oRD_BANK=0.
- Both banks FULL, read of bank0 in progress, iRD_DONE → next cycle oWR_ALLOW=1, oWR_BANK=0, oFRAME_CNT=1; oRD_START for bank1 follows one cycle later.
- iWR_DONE on bank1 in the same cycle as iRD_DONE for bank0 → oWR_BANK=0, oWR_ALLOW stays 1, oOVF=0.
- Stray iRD_DONE in R_IDLE → no change to bank states, rd_ptr or oFRAME_CNT. iRST asserted mid-read → all outputs at reset values next cycle.
- FRAME_CNT_WL=2, 5 full write/read frames → oFRAME_CNT sequence 1,2,3,0,1; oRD_BANK sequence 0,1,0,1,0.

Source files
------------

// File: rtl/mem1_bank_scheduler.sv
// Ping-pong bank scheduler for the MEM1 frame buffer: steers the SPI writer and
// the STFT/CNN reader across two image banks and flags write overruns.
module mem1_bank_scheduler #(
  parameter int unsigned FRAME_CNT_WL = 16
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iWR_DONE,
  input  logic                    iRD_READY,
  input  logic                    iRD_DONE,
  output logic                    oWR_BANK,
  output logic                    oWR_ALLOW,
  output logic                    oWR_CLR,
  output logic                    oRD_START,
  output logic                    oRD_BANK,
  output logic                    oRD_BUSY,
  output logic                    oOVF,
  output logic [FRAME_CNT_WL-1:0] oFRAME_CNT
);

  typedef enum logic [1:0] {B_FREE = 2'd0, B_FULL = 2'd1, B_READ = 2'd2} bank_st_t;
  typedef enum logic {W_ACTIVE = 1'b0, W_WAIT = 1'b1} wr_st_t;
  typedef enum logic {R_IDLE = 1'b0, R_BUSY = 1'b1} rd_st_t;

  bank_st_t                bank_q [2];
  bank_st_t                bank_d [2];
  wr_st_t                  wr_st_q, wr_st_d;
  rd_st_t                  rd_st_q, rd_st_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    rd_bank_q, rd_bank_d;
  logic                    wr_clr_q, wr_clr_d;
  logic                    rd_start_q, rd_start_d;
  logic                    ovf_q, ovf_d;
  logic [FRAME_CNT_WL-1:0] cnt_q, cnt_d;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bank_q[0]  <= B_FREE;
      bank_q[1]  <= B_FREE;
      wr_st_q    <= W_ACTIVE;
      rd_st_q    <= R_IDLE;
      wr_bank_q  <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_clr_q   <= 1'b0;
      rd_start_q <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      wr_st_q    <= wr_st_d;
      rd_st_q    <= rd_st_d;
      wr_bank_q  <= wr_bank_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_bank_q  <= rd_bank_d;
      wr_clr_q   <= wr_clr_d;
      rd_start_q <= rd_start_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    bank_d[0]  = bank_q[0];
    bank_d[1]  = bank_q[1];
    wr_st_d    = wr_st_q;
    rd_st_d    = rd_st_q;
    wr_bank_d  = wr_bank_q;
    rd_ptr_d   = rd_ptr_q;
    rd_bank_d  = rd_bank_q;
    wr_clr_d   = 1'b0;
    rd_start_d = 1'b0;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;

    // Reader resolves first so the writer sees a bank freed in this same cycle.
    unique case (rd_st_q)
      R_IDLE: begin
        if (iRD_READY && bank_q[rd_ptr_q] == B_FULL) begin
          rd_start_d       = 1'b1;
          rd_bank_d        = rd_ptr_q;
          bank_d[rd_ptr_q] = B_READ;
          rd_st_d          = R_BUSY;
        end
      end
      R_BUSY: begin
        if (iRD_DONE) begin
          bank_d[rd_bank_q] = B_FREE;
          rd_ptr_d          = ~rd_ptr_q;
          cnt_d             = cnt_q + FRAME_CNT_WL'(1);
          rd_st_d           = R_IDLE;
        end
      end
      default: rd_st_d = R_IDLE;
    endcase

    unique case (wr_st_q)
      W_ACTIVE: begin
        if (iWR_DONE) begin
          bank_d[wr_bank_q] = B_FULL;
          wr_clr_d          = 1'b1;
          if (bank_d[~wr_bank_q] == B_FREE) wr_bank_d = ~wr_bank_q;
          else                              wr_st_d   = W_WAIT;
        end
      end
      W_WAIT: begin
        if (iWR_DONE) ovf_d = 1'b1;
        if (bank_d[~wr_bank_q] == B_FREE) begin
          wr_bank_d = ~wr_bank_q;
          wr_st_d   = W_ACTIVE;
        end
      end
      default: wr_st_d = W_ACTIVE;
    endcase
  end

  assign oWR_BANK   = wr_bank_q;
  assign oWR_ALLOW  = (wr_st_q == W_ACTIVE);
  assign oWR_CLR    = wr_clr_q;
  assign oRD_START  = rd_start_q;
  assign oRD_BANK   = rd_bank_q;
  assign oRD_BUSY   = (rd_st_q == R_BUSY);
  assign oOVF       = ovf_q;
  assign oFRAME_CNT = cnt_q;

endmodule
